// File: rtl/count_stream_decoder.sv
// Purpose : observes a step/down up/down counter bus and recovers its step/down
//           controls from consecutive samples; tracks lock and illegal jumps.
// Latency : decode registered, 1 cycle after the en=1 sampling edge.
// Backpr. : none; en is a pure sample strobe and every strobed sample is consumed.
// Ports   : clk, nrst (async active-low), en (sample strobe), clr (clear err/err_cnt),
//           in[W] (observed counter) -> valid (decode pulse), step, down,
//           locked, err (sticky), err_cnt[ECNT_W] (saturating).
module count_stream_decoder #(
  parameter int W        = 4,
  parameter int LOCK_CNT = 3,
  parameter int ECNT_W   = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              clr,
  input  logic [W-1:0]      in,
  output logic              valid,
  output logic              step,
  output logic              down,
  output logic              locked,
  output logic              err,
  output logic [ECNT_W-1:0] err_cnt
);

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_SYNC   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  // Legal deltas in W-bit wrap arithmetic: +1, +2, -1, -2.
  localparam logic [W-1:0] D_UP1 = W'(1);
  localparam logic [W-1:0] D_UP2 = W'(2);
  localparam logic [W-1:0] D_DN1 = {W{1'b1}};
  localparam logic [W-1:0] D_DN2 = {W{1'b1}} - W'(1);

  // LOCK_CNT is bounded to 15, so a 4-bit run counter always suffices.
  localparam logic [3:0]        LOCK_N   = 4'(LOCK_CNT);
  localparam logic [ECNT_W-1:0] ECNT_MAX = {ECNT_W{1'b1}};
  localparam logic [ECNT_W-1:0] ECNT_ONE = ECNT_W'(1);

  logic [1:0]   state;
  logic [W-1:0] prev;
  logic [3:0]   run;

  logic [W-1:0] diff;
  logic         legal;
  logic         dec_step;
  logic         dec_down;
  logic         same_mode;
  logic [3:0]   run_next;
  logic         decoding;
  logic         illegal;

  assign diff = in - prev;

  always_comb begin
    legal    = 1'b1;
    dec_step = 1'b0;
    dec_down = 1'b0;
    case (diff)
      D_UP1: begin
        dec_step = 1'b0;
        dec_down = 1'b0;
      end
      D_UP2: begin
        dec_step = 1'b1;
        dec_down = 1'b0;
      end
      D_DN1: begin
        dec_step = 1'b0;
        dec_down = 1'b1;
      end
      D_DN2: begin
        dec_step = 1'b1;
        dec_down = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // step/down registers double as the "previous legal mode"; run != 0 guarantees
  // they hold a decode made since the last illegal sample or reset.
  assign same_mode = (dec_step == step) && (dec_down == down) && (run != 4'd0);

  always_comb begin
    run_next = 4'd1;
    if (same_mode) begin
      run_next = (run >= LOCK_N) ? LOCK_N : run + 4'd1;
    end
  end

  // A decode is only possible once prev has been primed by a first sample.
  assign decoding = en && (state != S_EMPTY);
  assign illegal  = decoding && !legal;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_EMPTY;
      prev  <= '0;
      run   <= 4'd0;
      valid <= 1'b0;
      step  <= 1'b0;
      down  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (en) begin
        prev <= in;
        if (state == S_EMPTY) begin
          state <= S_SYNC;
          run   <= 4'd0;
        end else if (legal) begin
          valid <= 1'b1;
          step  <= dec_step;
          down  <= dec_down;
          run   <= run_next;
          // A mode change resets run to 1, which also drops a held lock
          // unless LOCK_CNT is 1.
          state <= (run_next == LOCK_N) ? S_LOCKED : S_SYNC;
        end else begin
          run   <= 4'd0;
          state <= S_SYNC;
        end
      end
    end
  end

  // An illegal sample on the same edge as clr takes priority: the count
  // restarts at one instead of zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (illegal) begin
      err <= 1'b1;
      if (clr) begin
        err_cnt <= ECNT_ONE;
      end else if (err_cnt != ECNT_MAX) begin
        err_cnt <= err_cnt + ECNT_ONE;
      end
    end else if (clr) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end
  end

  assign locked = (state == S_LOCKED);

endmodule

// File: doc/count_stream_decoder.md
Name: count_stream_decoder

Overview:
- Receiving end of the 4-bit step/down up/down counter interface.
- Samples the counter's output bus on a qualifying strobe and reconstructs the `step` and `down` control inputs from consecutive samples.
- Declares lock once the decoded mode is stable and counts illegal transitions.
- Sits on the observing side of a counter, for monitoring or self-check logic.

Parameters:
- W, 4: sampled counter width; legal range W >= 3.
- LOCK_CNT, 3: consecutive legal samples with identical decoded mode required to assert `locked`; range 1..15.
- ECNT_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- en  input  1  sample strobe; `in` is captured on a rising clk edge with en=1.
- clr  input  1  synchronous clear of `err` and `err_cnt`.
- in  input  W  counter value being observed.
- valid  output  1  one-cycle pulse: the previous sample produced a legal decode.
- step  output  1  decoded step (0 = by 1, 1 = by 2); holds last legal decode.
- down  output  1  decoded direction (0 = up, 1 = down); holds last legal decode.
- locked  output  1  decoded mode stable for LOCK_CNT consecutive legal samples.
- err  output  1  sticky illegal-transition flag.
- err_cnt  output  ECNT_W  count of illegal transitions, saturating at 2^ECNT_W-1.

Behaviour:
- Reset (nrst=0, asynchronous):
  - State EMPTY; prev=0; run=0.
  - valid=0, step=0, down=0, locked=0, err=0, err_cnt=0.
- Clocks with en=0:
  - No state change; valid=0.
  - step, down, locked, err and err_cnt hold.
- State EMPTY, en=1:
  - prev<=in; go to SYNC; run=0; valid stays 0. No decode is possible from a single sample.
- States SYNC and LOCKED, en=1: compute d = (in - prev) mod 2^W, W-bit wrap arithmetic. Classification:
  - d=1: step=0, down=0.
  - d=2: step=1, down=0.
  - d=2^W-1: step=0, down=1.
  - d=2^W-2: step=1, down=1.
  - Any other d, including 0: illegal.
- Wrap-around is legal, e.g. W=4: 15->0 and 14->0 decode up; 0->15 and 1->15 decode down.
- Legal decode, outputs registered (1-cycle latency from the sampling edge):
  - valid=1 for exactly one cycle; step and down are updated.
  - If the mode equals the previous legal mode and run>0: run<=min(run+1, LOCK_CNT).
  - Otherwise run<=1.
  - When run reaches LOCK_CNT: state LOCKED, locked=1.
  - A mode change while LOCKED: state SYNC, locked=0, run=1.
- Illegal decode:
  - valid=0; step and down hold.
  - err<=1; err_cnt increments, saturating.
  - run<=0; state SYNC; locked=0.
- prev<=in on every en=1 sample, legal or not, so the decoder resyncs to the new value.
- clr=1: err<=0 and err_cnt<=0 on that edge. If an illegal decode occurs on the same edge, the error wins: err=1, err_cnt=1.
- clr does not affect state, run, prev, step, down or locked.
- Reset mid-operation discards prev; the first sample after reset only primes prev.
- LOCK_CNT=1: locked asserts on the first legal decode.

Test Plan:
- Reset, then en=1 every cycle with in=3,4,5,6,7 -> valid pulses from the 2nd sample; step=0, down=0; locked=1 one cycle after the 4th sample (run=3); err=0.
- in=14,0,2,4 (W=4) -> wrap 14->0 decodes step=1, down=0; locked after the 3rd legal decode.
- LOCKED on up-by-1 at in=5, then in=4,3,2,1 -> first decode step=0, down=1, locked drops; re-locks after three down-by-1 decodes.
- in=5,9 -> illegal (d=4): err=1, err_cnt=1, valid=0, locked=0; next sample in=10 decodes legally relative to 9.
- err_cnt=255 (ECNT_W=8) plus another illegal sample -> err_cnt stays 255. clr with a simultaneous illegal sample -> err=1, err_cnt=1.
- LOCKED, assert nrst=0 between clock edges -> all outputs 0 immediately. After release, first sample in=7 gives no valid; second sample in=8 gives valid.
